// File: rtl/dsi_packet_assembler_if.sv
// Bus bundle between a DSI packet source, the packet assembler and the data lane.
// Every channel is valid/ready: a beat moves on a cycle where valid & ready are both 1
// (lane_write acts as valid, lane_ready as ready); the sender holds its beat stable until then.
interface dsi_packet_assembler_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_vc;
  logic [5:0]  req_dt;
  logic        req_long;
  logic [15:0] req_wc;
  logic        req_last;

  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;

  logic [7:0]  lane_data;
  logic        lane_write;
  logic        lane_ready;
  logic        lane_hs;
  logic        lane_eof;
  logic        lane_dummy;

  modport master (
    output req_valid, req_vc, req_dt, req_long, req_wc, req_last,
    output pl_data, pl_valid, lane_ready,
    input  req_ready, pl_ready,
    input  lane_data, lane_write, lane_hs, lane_eof, lane_dummy
  );

  modport slave (
    input  req_valid, req_vc, req_dt, req_long, req_wc, req_last,
    input  pl_data, pl_valid, lane_ready,
    output req_ready, pl_ready,
    output lane_data, lane_write, lane_hs, lane_eof, lane_dummy
  );
endinterface

// File: rtl/dsi_packet_assembler.sv
// DSI packet assembler: turns packet requests plus a payload byte stream into
// header / payload / CRC bytes on the data lane's byte-write interface.
module dsi_packet_assembler #(
  parameter logic [15:0] CRC_INIT     = 16'hFFFF,
  parameter logic [15:0] CRC_POLY_REV = 16'h8408
) (
  input  logic                    clk_base,
  input  logic                    reset_n,
  dsi_packet_assembler_if.slave   bus,
  output logic                    busy,
  output logic                    pkt_done,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_DI, S_HDR_D0, S_HDR_D1, S_HDR_ECC, S_PAYLOAD, S_CRC_LO, S_CRC_HI
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  vc_q;
  logic [5:0]  dt_q;
  logic [15:0] wc_q;
  logic [15:0] cnt_q;
  logic [15:0] crc_q;
  logic        long_q;
  logic        last_q;
  logic        pkt_done_q;

  logic        accept;
  logic        xfer;
  logic        final_xfer;
  logic [23:0] hdr;
  logic [5:0]  ecc6;

  // Reflected CRC-16: one byte, LSB first, no final XOR.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY_REV;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign hdr = {wc_q, vc_q, dt_q};

  // DSI Hamming parity bits over the 24-bit header, bit 0 = DI[0].
  assign ecc6[0] = hdr[0] ^ hdr[1] ^ hdr[2] ^ hdr[4] ^ hdr[5] ^ hdr[7] ^ hdr[10] ^ hdr[11]
                 ^ hdr[13] ^ hdr[16] ^ hdr[20] ^ hdr[21] ^ hdr[22] ^ hdr[23];
  assign ecc6[1] = hdr[0] ^ hdr[1] ^ hdr[3] ^ hdr[4] ^ hdr[6] ^ hdr[8] ^ hdr[10] ^ hdr[12]
                 ^ hdr[14] ^ hdr[17] ^ hdr[20] ^ hdr[21] ^ hdr[22] ^ hdr[23];
  assign ecc6[2] = hdr[0] ^ hdr[2] ^ hdr[3] ^ hdr[5] ^ hdr[6] ^ hdr[9] ^ hdr[11] ^ hdr[12]
                 ^ hdr[15] ^ hdr[18] ^ hdr[20] ^ hdr[21] ^ hdr[22];
  assign ecc6[3] = hdr[1] ^ hdr[2] ^ hdr[3] ^ hdr[7] ^ hdr[8] ^ hdr[9] ^ hdr[13] ^ hdr[14]
                 ^ hdr[15] ^ hdr[19] ^ hdr[20] ^ hdr[21] ^ hdr[23];
  assign ecc6[4] = hdr[4] ^ hdr[5] ^ hdr[6] ^ hdr[7] ^ hdr[8] ^ hdr[9] ^ hdr[16] ^ hdr[17]
                 ^ hdr[18] ^ hdr[19] ^ hdr[20] ^ hdr[22] ^ hdr[23];
  assign ecc6[5] = hdr[10] ^ hdr[11] ^ hdr[12] ^ hdr[13] ^ hdr[14] ^ hdr[15] ^ hdr[16]
                 ^ hdr[17] ^ hdr[18] ^ hdr[19] ^ hdr[21] ^ hdr[22] ^ hdr[23];

  assign accept     = (state == S_IDLE) && bus.req_valid;
  assign xfer       = bus.lane_write && bus.lane_ready;
  assign final_xfer = xfer && (((state == S_HDR_ECC) && !long_q) || (state == S_CRC_HI));

  always_ff @(posedge clk_base) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      vc_q       <= '0;
      dt_q       <= '0;
      wc_q       <= '0;
      cnt_q      <= '0;
      crc_q      <= '0;
      long_q     <= 1'b0;
      last_q     <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      pkt_done_q <= final_xfer;
      if (accept) begin
        vc_q   <= bus.req_vc;
        dt_q   <= bus.req_dt;
        wc_q   <= bus.req_wc;
        long_q <= bus.req_long;
        last_q <= bus.req_last;
        crc_q  <= CRC_INIT;
        cnt_q  <= bus.req_wc;
      end else if ((state == S_PAYLOAD) && xfer) begin
        crc_q <= crc_byte(crc_q, bus.pl_data);
        cnt_q <= cnt_q - 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = S_HDR_DI;
      S_HDR_DI:  if (xfer)   state_nxt = S_HDR_D0;
      S_HDR_D0:  if (xfer)   state_nxt = S_HDR_D1;
      S_HDR_D1:  if (xfer)   state_nxt = S_HDR_ECC;
      S_HDR_ECC: begin
        if (xfer) begin
          if (!long_q)          state_nxt = S_IDLE;
          else if (wc_q == '0)  state_nxt = S_CRC_LO;
          else                  state_nxt = S_PAYLOAD;
        end
      end
      // Leaving at cnt==1 means wc=65535 never needs a wrapped count.
      S_PAYLOAD: if (xfer && (cnt_q == 16'd1)) state_nxt = S_CRC_LO;
      S_CRC_LO:  if (xfer) state_nxt = S_CRC_HI;
      S_CRC_HI:  if (xfer) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.lane_data  = '0;
    bus.lane_write = 1'b0;
    bus.req_ready  = 1'b0;
    bus.pl_ready   = 1'b0;
    case (state)
      S_IDLE:    bus.req_ready = 1'b1;
      S_HDR_DI:  begin bus.lane_data = {vc_q, dt_q};  bus.lane_write = 1'b1; end
      S_HDR_D0:  begin bus.lane_data = wc_q[7:0];     bus.lane_write = 1'b1; end
      S_HDR_D1:  begin bus.lane_data = wc_q[15:8];    bus.lane_write = 1'b1; end
      S_HDR_ECC: begin bus.lane_data = {2'b00, ecc6}; bus.lane_write = 1'b1; end
      S_PAYLOAD: begin
        bus.lane_data  = bus.pl_data;
        bus.lane_write = bus.pl_valid;
        bus.pl_ready   = bus.lane_ready;
      end
      S_CRC_LO:  begin bus.lane_data = crc_q[7:0];    bus.lane_write = 1'b1; end
      S_CRC_HI:  begin bus.lane_data = crc_q[15:8];   bus.lane_write = 1'b1; end
      default:   bus.req_ready = 1'b0;
    endcase
  end

  assign bus.lane_hs    = 1'b1;
  assign bus.lane_dummy = bus.lane_write;
  assign bus.lane_eof   = last_q && (((state == S_HDR_ECC) && !long_q) || (state == S_CRC_HI));
  assign busy           = (state != S_IDLE);
  assign pkt_done       = pkt_done_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// Bench for dsi_packet_assembler: expected byte stream built per packet from the
// DSI header/ECC/CRC rules, compared against the lane every cycle.
module tb_dsi_packet_assembler;

  logic       clk_base;
  logic       reset_n;
  logic       busy;
  logic       pkt_done;
  logic [2:0] state_dbg;

  dsi_packet_assembler_if bus();

  dsi_packet_assembler dut (
    .clk_base  (clk_base),
    .reset_n   (reset_n),
    .bus       (bus),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_base = 1'b0;
    forever #5 clk_base = ~clk_base;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  // entry = {is_payload, final_byte, eof, data}
  logic [10:0] exp_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  ref_q[$];
  logic [7:0]  lit_q[$];
  bit          in_pkt    = 0;
  bit          done_next = 0;
  bit          prev_hold = 0;
  bit          rand_lane = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [5:0] ecc_model(input logic [23:0] h);
    logic [23:0] m [0:5];
    logic [5:0]  e;
    m = '{24'hF12CB7, 24'hF2555B, 24'h749A6D, 24'hB8E38E, 24'hDF03F0, 24'hEFFC00};
    for (int i = 0; i < 6; i++) e[i] = ^(h & m[i]);
    return e;
  endfunction

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  task automatic chk_got(input string name);
    chk({name, "_len"}, 16'(got_q.size()), 16'(lit_q.size()));
    for (int i = 0; i < lit_q.size(); i++)
      if (i < got_q.size()) chk(name, {8'h00, got_q[i]}, {8'h00, lit_q[i]});
  endtask

  // ---------------- compare process (every cycle, away from the edge) ----------------
  always @(negedge clk_base) begin
    if (!reset_n) begin
      exp_q.delete();
      in_pkt    = 0;
      done_next = 0;
      prev_hold = 0;
    end else begin
      bit          have;
      bit          exp_write;
      logic [10:0] front;
      have  = in_pkt && (exp_q.size() > 0);
      front = have ? exp_q[0] : 11'h0;
      exp_write = have && (!front[10] || bus.pl_valid);
      chk("busy",       {15'h0, busy},           {15'h0, in_pkt});
      chk("req_ready",  {15'h0, bus.req_ready},  {15'h0, !in_pkt});
      chk("lane_write", {15'h0, bus.lane_write}, {15'h0, exp_write});
      chk("lane_dummy", {15'h0, bus.lane_dummy}, {15'h0, exp_write});
      chk("lane_hs",    {15'h0, bus.lane_hs},    16'h1);
      chk("pl_ready",   {15'h0, bus.pl_ready},   {15'h0, have && front[10] && bus.lane_ready});
      chk("pkt_done",   {15'h0, pkt_done},       {15'h0, done_next});
      if (exp_write) begin
        chk("lane_data", {8'h0, bus.lane_data}, {8'h0, front[7:0]});
        chk("lane_eof",  {15'h0, bus.lane_eof}, {15'h0, front[8]});
      end else if (!in_pkt) begin
        chk("idle_data", {8'h0, bus.lane_data}, 16'h0);
        chk("idle_eof",  {15'h0, bus.lane_eof}, 16'h0);
      end
      if (prev_hold) chk("hold_write", {15'h0, bus.lane_write}, 16'h1);
      prev_hold = bus.lane_write && !bus.lane_ready;
      done_next = 0;
      if (bus.lane_write && bus.lane_ready) begin
        got_q.push_back(bus.lane_data);
        if (have) begin
          if (front[9]) begin
            done_next = 1;
            in_pkt    = 0;
          end
          void'(exp_q.pop_front());
        end
      end
      if (bus.req_valid && bus.req_ready) in_pkt = 1;
    end
  end

  // ---------------- lane_ready driver ----------------
  initial begin
    bus.lane_ready = 1'b1;
    forever begin
      @(posedge clk_base);
      #1;
      bus.lane_ready = rand_lane ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- packet driver ----------------
  task automatic send_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic lng,
                          input logic [15:0] wc, input logic lst, input logic [7:0] base,
                          input logic [7:0] step, input bit stall, input int abort_at);
    logic [15:0] crc;
    logic [7:0]  b;
    logic [7:0]  di;
    bit          c;
    int          guard;
    int          npl;
    di  = {vc, dt};
    npl = lng ? int'(wc) : 0;
    exp_q.push_back({3'b000, di});
    exp_q.push_back({3'b000, wc[7:0]});
    exp_q.push_back({3'b000, wc[15:8]});
    exp_q.push_back({1'b0, !lng, !lng && lst, 2'b00, ecc_model({wc, di})});
    if (lng) begin
      crc = 16'hFFFF;
      for (int i = 0; i < npl; i++) begin
        b   = base + step * 8'(i);
        crc = crc_model(crc, b);
        exp_q.push_back({3'b100, b});
      end
      exp_q.push_back({3'b000, crc[7:0]});
      exp_q.push_back({1'b0, 1'b1, lst, crc[15:8]});
    end

    bus.req_vc = vc; bus.req_dt = dt; bus.req_long = lng; bus.req_wc = wc; bus.req_last = lst;
    bus.req_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk_base);
      c = bus.req_ready;
      @(posedge clk_base);
      #1;
      guard++;
    end while (!c && guard < 20);
    bus.req_valid = 1'b0;
    if (!c) chk("req_accept_timeout", 16'h0, 16'h1);

    for (int i = 0; i < npl; i++) begin
      bus.pl_data = base + step * 8'(i);
      if (i == abort_at) begin
        bus.pl_valid = 1'b1;
        reset_n = 1'b0;
        @(posedge clk_base);
        #1;
        reset_n = 1'b1;
        bus.pl_valid = 1'b0;
        return;
      end
      if (stall) begin
        while ($urandom_range(0, 2) == 0) begin
          bus.pl_valid = 1'b0;
          @(posedge clk_base);
          #1;
        end
      end
      bus.pl_valid = 1'b1;
      guard = 0;
      do begin
        @(negedge clk_base);
        c = bus.pl_ready;
        @(posedge clk_base);
        #1;
        guard++;
      end while (!c && guard < 200);
      if (!c) chk("pl_accept_timeout", 16'h0, 16'h1);
    end
    bus.pl_valid = 1'b0;

    c = 0;
    for (int g = 0; g < 400 && !c; g++) begin
      @(negedge clk_base);
      c = pkt_done;
    end
    if (!c) begin
      $display("note: state_dbg=%0d at pkt_done timeout", state_dbg);
      chk("pkt_done_timeout", 16'h0, 16'h1);
    end
    @(posedge clk_base);
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [15:0] crc;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_vc    = '0;
    bus.req_dt    = '0;
    bus.req_long  = 1'b0;
    bus.req_wc    = '0;
    bus.req_last  = 1'b0;
    bus.pl_data   = '0;
    bus.pl_valid  = 1'b0;
    repeat (3) @(posedge clk_base);
    #1;
    reset_n = 1'b1;
    @(negedge clk_base);
    chk("rst_busy",       {15'h0, busy},           16'h0);
    chk("rst_req_ready",  {15'h0, bus.req_ready},  16'h1);
    chk("rst_lane_write", {15'h0, bus.lane_write}, 16'h0);
    chk("rst_pl_ready",   {15'h0, bus.pl_ready},   16'h0);
    chk("rst_pkt_done",   {15'h0, pkt_done},       16'h0);
    @(posedge clk_base);
    #1;

    // Pin the bench's own ECC/CRC model against hand-computed values.
    chk("model_ecc_a", {10'h0, ecc_model(24'h001105)}, 16'h0036);
    chk("model_ecc_b", {10'h0, ecc_model(24'h002905)}, 16'h001C);
    crc = 16'hFFFF;
    for (int i = 0; i < 9; i++) crc = crc_model(crc, 8'h31 + 8'(i));
    chk("model_crc_check", crc, 16'h6F91);

    // Back-to-back short packets.
    got_q.delete();
    send_pkt(2'd0, 6'h05, 1'b0, 16'h0011, 1'b1, 8'h00, 8'h00, 0, -1);
    lit_q = '{8'h05, 8'h11, 8'h00, 8'h36};
    chk_got("short_last");
    got_q.delete();
    send_pkt(2'd0, 6'h05, 1'b0, 16'h0029, 1'b0, 8'h00, 8'h00, 0, -1);
    lit_q = '{8'h05, 8'h29, 8'h00, 8'h1C};
    chk_got("short_notlast");

    // Long packet, CRC check string.
    got_q.delete();
    send_pkt(2'd0, 6'h39, 1'b1, 16'd9, 1'b1, 8'h31, 8'h01, 0, -1);
    lit_q = '{8'h39, 8'h09, 8'h00, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
              8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};
    chk_got("long_wc9");

    // Zero-length long packet with a payload byte offered that must not be taken.
    got_q.delete();
    bus.pl_data  = 8'hAB;
    bus.pl_valid = 1'b1;
    send_pkt(2'd0, 6'h39, 1'b1, 16'd0, 1'b1, 8'h00, 8'h00, 0, -1);
    bus.pl_valid = 1'b0;
    lit_q = '{8'h39, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'hFF};
    chk_got("long_wc0");

    // Same wc=16 packet without and with backpressure/bubbles.
    got_q.delete();
    send_pkt(2'd2, 6'h29, 1'b1, 16'd16, 1'b1, 8'hA5, 8'd13, 0, -1);
    ref_q = got_q;
    chk("ref_len", 16'(ref_q.size()), 16'd22);
    got_q.delete();
    rand_lane = 1;
    send_pkt(2'd2, 6'h29, 1'b1, 16'd16, 1'b1, 8'hA5, 8'd13, 1, -1);
    rand_lane = 0;
    lit_q = ref_q;
    chk_got("stall_same_stream");

    // Reset while payload byte 5 is on the lane, then a clean short packet.
    send_pkt(2'd1, 6'h2A, 1'b1, 16'd10, 1'b1, 8'h10, 8'h01, 0, 4);
    @(negedge clk_base);
    chk("abort_busy",       {15'h0, busy},           16'h0);
    chk("abort_lane_write", {15'h0, bus.lane_write}, 16'h0);
    chk("abort_req_ready",  {15'h0, bus.req_ready},  16'h1);
    @(posedge clk_base);
    #1;
    got_q.delete();
    send_pkt(2'd1, 6'h05, 1'b0, 16'h0011, 1'b1, 8'h00, 8'h00, 0, -1);
    lit_q = '{8'h45, 8'h11, 8'h00, 8'h20};
    chk_got("after_reset_short");

    repeat (3) @(posedge clk_base);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsi_packet_assembler.md
Name: dsi_packet_assembler

Overview:
- Upstream neighbour of the DSI data lane. Turns packet requests plus a payload byte stream into the lane's byte-write interface.
- Short packets: 4-byte header (DI, data0, data1, ECC).
- Long packets: header, then WC payload bytes, then a 2-byte CRC.
- Several packets can be chained into one HS burst; end_of_frame marks the final byte of the burst.

Parameters:
CRC_INIT, 16'hFFFF, CRC seed loaded at the start of each long packet
CRC_POLY_REV, 16'h8408, reflected CRC-16-CCITT polynomial, processed LSB-first per byte

Ports:
clk_base  in  1  logic clock
reset_n  in  1  synchronous active-low reset, sampled on rising clk_base
req_valid  in  1  packet request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_vc  in  2  virtual channel
req_dt  in  6  data type
req_long  in  1  1 = long packet, 0 = short packet
req_wc  in  16  long: word count; short: {data1, data0}
req_last  in  1  last packet of the HS burst
pl_data  in  8  payload byte
pl_valid  in  1  payload byte valid
pl_ready  out  1  payload byte consumed when pl_valid & pl_ready
lane_data  out  8  byte to lane (data_input)
lane_write  out  1  byte valid (data_write)
lane_ready  in  1  lane can accept (data_ready)
lane_hs  out  1  data_type to lane; constant 1
lane_eof  out  1  end_of_frame qualifier for the current byte
lane_dummy  out  1  dummy_frame to lane; held 1 whenever lane_write=1 (payload-present)
busy  out  1  high in any state other than IDLE
pkt_done  out  1  one-cycle pulse after a packet's final byte transfers

Behaviour:
- Transfer rule: a byte transfers on a cycle where lane_write & lane_ready. lane_data, lane_eof and lane_dummy stay stable while lane_write=1 and no transfer has occurred.
- Reset (any cycle, including mid-packet):
  - state=IDLE.
  - lane_write=0, lane_data=0, lane_eof=0, lane_dummy=0.
  - req_ready=1, pl_ready=0, busy=0, pkt_done=0.
  - Latched fields cleared. A partial packet is abandoned.
- States: IDLE, HDR_DI, HDR_D0, HDR_D1, HDR_ECC, PAYLOAD, CRC_LO, CRC_HI.
- IDLE:
  - req_ready=1, lane_write=0.
  - On request accept: latch vc, dt, wc, long, last; crc<=CRC_INIT; cnt<=req_wc; go to HDR_DI on the next cycle.
  - Request-to-first-byte latency is 1 cycle.
- HDR_DI / HDR_D0 / HDR_D1: lane_data = {vc,dt} / wc[7:0] / wc[15:8]. lane_write=1. Advance on transfer.
- HDR_ECC:
  - lane_data = {2'b00, ecc6}. ecc6 is the DSI 6-bit Hamming ECC over the 24-bit header {wc[15:8], wc[7:0], DI}, bit0 = DI[0]. ECC is computed combinationally from the latched fields.
  - On transfer:
    - Short packet: go to IDLE.
    - Long packet with wc=0: go to CRC_LO.
    - Long packet with wc>0: go to PAYLOAD.
- PAYLOAD:
  - Combinational pass-through: lane_data=pl_data, lane_write=pl_valid, pl_ready=lane_ready. pl_ready=0 in every other state.
  - On each transfer: crc updates with pl_data (8 LSB-first shift/xor steps), cnt decrements.
  - Transfer at cnt==1 goes to CRC_LO.
- CRC_LO / CRC_HI: lane_data = crc[7:0] / crc[15:8]. No final XOR. CRC_HI transfer goes to IDLE.
- lane_eof=1 only on the final byte of a packet whose last=1: ECC byte for short, CRC_HI for long. Otherwise 0.
- pkt_done pulses on the cycle after the final byte transfers. A new request may be accepted in that same cycle (IDLE), so back-to-back packets have a 1-cycle gap.
- Stalls: lane_ready low holds the state indefinitely with outputs stable. pl_valid low in PAYLOAD inserts bubbles with no CRC/cnt change.
- Requests arriving outside IDLE are ignored (req_ready=0). Extra payload bytes are not consumed outside PAYLOAD.
- All counters and the CRC are 16-bit. wc=65535 is legal; no wrap occurs because the transition happens at cnt==1.

Test Plan:
- Short packet, lane_ready=1: vc=0, dt=0x05, long=0, wc=0x0011, last=1 -> bytes 05 11 00 36 on 4 consecutive cycles; lane_eof only on 0x36; pkt_done one cycle later.
- Short packet: dt=0x05, wc=0x0029, last=0 -> 05 29 00 1C; lane_eof never asserted.
- Long packet: dt=0x39, wc=9, payload "123456789" (0x31..0x39), last=1 -> header 39 09 00 ECC, then the 9 bytes, then 91 6F; lane_eof on 0x6F.
- Long packet wc=0 -> 4 header bytes, then FF FF; pl_ready never asserted.
- Backpressure: random lane_ready and pl_valid toggling during a wc=16 long packet -> byte stream identical to the no-stall run; no byte duplicated or dropped; outputs stable while stalled.
- Reset asserted during PAYLOAD byte 5 -> next cycle IDLE, lane_write=0, busy=0; a following short request produces a correct 4-byte packet.
